// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: sequencer state encoding, block/digest widths,
// initial hash value and round constant table (also used by sha256_core).
package sha256_pkg;

  localparam int ShaBlockWidth  = 512;
  localparam int ShaDigestWidth = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } sha_seq_state_e;

  localparam logic [0:7][31:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_seq_watchdog.sv
// Cycle counter for the sequencer's core-response watchdog; expired asserts on
// the Limit-th enabled cycle after clear. Used only with SHA256_SEQ_TIMEOUT_EN.
module sha256_seq_watchdog #(
  parameter int Limit = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(Limit) + 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(Limit - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Feeds padded 512-bit blocks to sha256_core as init/next commands and returns
// the final digest. Optional core watchdog: define SHA256_SEQ_TIMEOUT_EN.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int BlockWidth    = ShaBlockWidth,
  parameter int DigestWidth   = ShaDigestWidth,
  parameter int CntWidth      = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [BlockWidth-1:0]  blk_i,
  input  logic                   blk_first_i,
  input  logic                   blk_last_i,
  output logic [BlockWidth-1:0]  core_block_o,
  output logic                   core_init_o,
  output logic                   core_next_o,
  input  logic                   core_ready_i,
  input  logic [DigestWidth-1:0] core_digest_i,
  input  logic                   core_digest_valid_i,
  output logic [DigestWidth-1:0] dig_o,
  output logic                   dig_valid_o,
  input  logic                   dig_ready_i,
  output logic [CntWidth-1:0]    blk_cnt_o,
  output logic                   busy_o,
  output logic                   err_o
);

  sha_seq_state_e         state;
  logic [BlockWidth-1:0]  blk_q;
  logic                   first_q, last_q, chain_active;
  logic [DigestWidth-1:0] dig_q;
  logic [CntWidth-1:0]    cnt_q;
  logic                   accept, issue, timeout, wd_expired;

  assign accept  = (state == ST_IDLE) & blk_valid_i;
  assign issue   = (state == ST_ISSUE) & core_ready_i;
  // A digest arriving on the expiry cycle still wins over the timeout.
  assign timeout = (state == ST_WAIT) & wd_expired & ~core_digest_valid_i;

  assign blk_ready_o  = (state == ST_IDLE);
  assign core_block_o = blk_q;
  assign core_init_o  = issue & first_q;
  assign core_next_o  = issue & ~first_q;
  assign dig_o        = dig_q;
  assign dig_valid_o  = (state == ST_OUT);
  assign blk_cnt_o    = cnt_q;
  assign busy_o       = (state != ST_IDLE);
  assign err_o        = (accept & ~blk_first_i & ~chain_active) | timeout;

`ifdef SHA256_SEQ_TIMEOUT_EN
  sha256_seq_watchdog #(.Limit(TimeoutCycles)) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr     (state != ST_WAIT),
    .en      (state == ST_WAIT),
    .expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TimeoutCycles;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      blk_q        <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      chain_active <= 1'b0;
      dig_q        <= '0;
      cnt_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          blk_q   <= blk_i;
          // No live chain means there is nothing to continue from: force init.
          first_q <= blk_first_i | ~chain_active;
          last_q  <= blk_last_i;
          state   <= ST_ISSUE;
        end
        ST_ISSUE: if (core_ready_i) begin
          state <= ST_WAIT;
          if (first_q)          cnt_q <= CntWidth'(1);
          else if (cnt_q != '1) cnt_q <= cnt_q + CntWidth'(1);
        end
        ST_WAIT: begin
          if (core_digest_valid_i) begin
            if (last_q) begin
              dig_q        <= core_digest_i;
              chain_active <= 1'b0;
              state        <= ST_OUT;
            end else begin
              chain_active <= 1'b1;
              state        <= ST_IDLE;
            end
          end else if (timeout) begin
            chain_active <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_OUT: if (dig_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer: the bench plays the core, queues
// expected commands/digests, and independent monitors compare DUT outputs.
module tb_sha256_block_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid, blk_first, blk_last;
  logic [511:0] blk;
  logic         blk_ready;
  logic [511:0] core_block_o;
  logic         core_init_o, core_next_o;
  logic         core_ready;
  logic [255:0] core_digest;
  logic         core_digest_valid;
  logic [255:0] dig_o;
  logic         dig_valid_o;
  logic         dig_ready;
  logic [31:0]  blk_cnt_o;
  logic         busy_o, err_o;

  always #5 clk = ~clk;

  sha256_block_sequencer #(.TimeoutCycles(16)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .blk_valid_i         (blk_valid),
    .blk_ready_o         (blk_ready),
    .blk_i               (blk),
    .blk_first_i         (blk_first),
    .blk_last_i          (blk_last),
    .core_block_o        (core_block_o),
    .core_init_o         (core_init_o),
    .core_next_o         (core_next_o),
    .core_ready_i        (core_ready),
    .core_digest_i       (core_digest),
    .core_digest_valid_i (core_digest_valid),
    .dig_o               (dig_o),
    .dig_valid_o         (dig_valid_o),
    .dig_ready_i         (dig_ready),
    .blk_cnt_o           (blk_cnt_o),
    .busy_o              (busy_o),
    .err_o               (err_o)
  );

  typedef struct { logic init; logic [511:0] blk; } cmd_t;
  typedef struct { logic [255:0] dig; logic [31:0] cnt; } dig_t;

  cmd_t exp_cmd[$];
  dig_t exp_dig[$];
  int   checks = 0, errors = 0;
  int   cmd_seen = 0, err_seen = 0, cmd_base = 0;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_L1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_L2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_L   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DIG_MID = 256'h0123456789abcdef_fedcba9876543210_55aa55aa55aa55aa_0f0f0f0f0f0f0f0f;
  localparam logic [255:0] DIG_X   = 256'hdeadbeef_00000000_cafef00d_11111111_22222222_33333333_44444444_55555555;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Command monitor: every init/next pulse must match the next queued command.
  always @(negedge clk) begin
    cmd_t c;
    #2;
    if (core_init_o || core_next_o) begin
      if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cmd init=%0b next=%0b", core_init_o, core_next_o);
      end else begin
        c = exp_cmd.pop_front();
        chk("cmd_type", {510'h0, core_init_o, core_next_o}, {510'h0, c.init, ~c.init});
        chk("cmd_block", core_block_o, c.blk);
      end
      cmd_seen++;
    end
    if (err_o) err_seen++;
  end

  // Digest monitor: each digest handshake is compared with the next queued result.
  always @(negedge clk) begin
    dig_t d;
    #2;
    if (dig_valid_o && dig_ready) begin
      if (exp_dig.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_digest got=%0h", dig_o);
      end else begin
        d = exp_dig.pop_front();
        chk("digest", {256'h0, dig_o}, {256'h0, d.dig});
        chk("blk_cnt", {480'h0, blk_cnt_o}, {480'h0, d.cnt});
      end
    end
  end

  task automatic send(input logic [511:0] b, input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    cmd_base  = cmd_seen;
    blk_valid = 1'b1; blk = b; blk_first = f; blk_last = l;
    while (!blk_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL blk_accept_timeout got=busy exp=ready");
    end
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (cmd_seen == cmd_base && n < 100) begin @(negedge clk); #2; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL cmd_timeout got=none exp=pulse");
    end
  endtask

  task automatic respond(input logic [255:0] d);
    @(negedge clk);
    core_digest_valid = 1'b1; core_digest = d;
    @(negedge clk);
    core_digest_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin @(negedge clk); #2; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  initial begin
    int e0, n;
    rst_n = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; blk = '0;
    core_ready = 1'b1; core_digest = '0; core_digest_valid = 1'b0; dig_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_blk_ready", {511'h0, blk_ready}, 512'h1);
    chk("rst_outputs", {506'h0, core_init_o, core_next_o, dig_valid_o, busy_o, err_o, |dig_o}, 512'h0);
    chk("rst_blk_cnt", {480'h0, blk_cnt_o}, 512'h0);
    chk("rst_core_block", core_block_o, 512'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single-block "abc".
    exp_cmd.push_back('{1'b1, BLK_ABC});
    exp_dig.push_back('{DIG_ABC, 32'd1});
    send(BLK_ABC, 1'b1, 1'b1); wait_cmd(); respond(DIG_ABC); wait_idle();

    // Two-block message: init then next.
    exp_cmd.push_back('{1'b1, BLK_L1});
    exp_cmd.push_back('{1'b0, BLK_L2});
    exp_dig.push_back('{DIG_L, 32'd2});
    send(BLK_L1, 1'b1, 1'b0); wait_cmd(); respond(DIG_MID);
    send(BLK_L2, 1'b0, 1'b1); wait_cmd();
    chk("cnt_after_next", {480'h0, blk_cnt_o}, 512'd2);
    respond(DIG_L); wait_idle();

    // Core backpressure, then consumer backpressure.
    core_ready = 1'b0; dig_ready = 1'b0;
    exp_cmd.push_back('{1'b1, BLK_ABC});
    exp_dig.push_back('{DIG_ABC, 32'd1});
    send(BLK_ABC, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_blk_ready", {511'h0, blk_ready}, 512'h0);
      chk("bp_no_pulse", {510'h0, core_init_o, core_next_o}, 512'h0);
      @(negedge clk);
    end
    core_ready = 1'b1;
    #2 chk("bp_pulse_on_ready", {511'h0, core_init_o}, 512'h1);
    wait_cmd(); respond(DIG_ABC);
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("stall_valid", {511'h0, dig_valid_o}, 512'h1);
      chk("stall_digest", {256'h0, dig_o}, {256'h0, DIG_ABC});
      @(negedge clk);
    end
    dig_ready = 1'b1;
    wait_idle();

    // Reset while waiting for the core: late digest must be ignored.
    exp_cmd.push_back('{1'b1, BLK_L1});
    send(BLK_L1, 1'b1, 1'b1); wait_cmd();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    respond(DIG_X);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_wait_idle", {510'h0, busy_o, dig_valid_o}, 512'h0);
      @(negedge clk);
    end
    chk("rst_wait_cnt", {480'h0, blk_cnt_o}, 512'h0);

    // Non-first block with no chain: init plus one err pulse.
    e0 = err_seen;
    exp_cmd.push_back('{1'b1, BLK_L2});
    exp_dig.push_back('{DIG_X, 32'd1});
    send(BLK_L2, 1'b0, 1'b1); wait_cmd(); respond(DIG_X); wait_idle();
    chk("proto_err_count", 512'(err_seen - e0), 512'd1);

    // First flag mid-chain restarts silently.
    e0 = err_seen;
    exp_cmd.push_back('{1'b1, BLK_L1});
    exp_cmd.push_back('{1'b1, BLK_ABC});
    exp_cmd.push_back('{1'b0, BLK_L2});
    exp_dig.push_back('{DIG_L, 32'd2});
    send(BLK_L1, 1'b1, 1'b0); wait_cmd(); respond(DIG_MID);
    send(BLK_ABC, 1'b1, 1'b0); wait_cmd();
    chk("restart_cnt", {480'h0, blk_cnt_o}, 512'd1);
    respond(DIG_MID);
    send(BLK_L2, 1'b0, 1'b1); wait_cmd(); respond(DIG_L); wait_idle();
    chk("restart_no_err", 512'(err_seen - e0), 512'd0);

`ifdef SHA256_SEQ_TIMEOUT_EN
    // Core never answers: err on the 16th WAIT cycle, then idle.
    e0 = err_seen;
    exp_cmd.push_back('{1'b1, BLK_ABC});
    send(BLK_ABC, 1'b1, 1'b1); wait_cmd();
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!err_o && n < 100);
    chk("timeout_cycle", 512'(n), 512'd16);
    @(negedge clk); #2;
    chk("timeout_busy", {511'h0, busy_o}, 512'h0);
    chk("timeout_err_count", 512'(err_seen - e0), 512'd1);
`else
    // Without the watchdog WAIT holds indefinitely.
    exp_cmd.push_back('{1'b1, BLK_ABC});
    exp_dig.push_back('{DIG_MID, 32'd1});
    send(BLK_ABC, 1'b1, 1'b1); wait_cmd();
    n = 0;
    repeat (40) begin @(negedge clk); n++; end
    #2;
    chk("wait_hold_busy", {510'h0, busy_o, dig_valid_o}, 512'h2);
    chk("wait_hold_cycles", 512'(n), 512'd40);
    respond(DIG_MID); wait_idle();
`endif

    repeat (3) @(negedge clk);
    chk("cmd_queue_drained", 512'(exp_cmd.size()), 512'd0);
    chk("dig_queue_drained", 512'(exp_dig.size()), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
